// File: rtl/parallax_starfield_pkg.sv
// Shared types and helpers for the parallax starfield generator.
//   state_e     : two-state scroll controller encoding
//   SEED_STRIDE : per-layer seed offset added to SEED_BASE
//   lfsr_step   : one Galois step of a w-bit LFSR (w <= 32)
package parallax_starfield_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

    localparam logic [15:0] SEED_STRIDE = 16'h1F3D;

    // Shift left and fold the feedback mask in when the MSB falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s,
                                              input logic [31:0] taps,
                                              input int          w);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r    = (s << 1) ^ (s[w-1] ? taps : 32'd0);
        return r & mask;
    endfunction

endpackage

// File: rtl/parallax_starfield_layer.sv
// One star layer: a Galois LFSR plus its extra-step counter.
//   clk, reset  : pixel clock, async active-low reset
//   step_pix    : advance one step for the current window pixel
//   load_cnt    : load speed into the extra-step counter
//   speed       : extra steps to run during vertical blank
//   lfsr        : current LFSR state
//   cnt_zero    : counter is empty
//   cnt_one     : counter holds its final step
//   lit_raw     : top D bits of the LFSR are all ones
module starfield_layer
    import parallax_starfield_pkg::*;
#(
    parameter int             W    = 16,
    parameter int             D    = 7,
    parameter logic [W-1:0]   TAPS = 16'h100B,
    parameter logic [W-1:0]   SEED = 16'h0001
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step_pix,
    input  logic         load_cnt,
    input  logic [3:0]   speed,
    output logic [W-1:0] lfsr,
    output logic         cnt_zero,
    output logic         cnt_one,
    output logic         lit_raw
);

    logic [W-1:0] r_lfsr;
    logic [3:0]   r_cnt;
    logic [W-1:0] w_next;
    logic         w_step;

    assign w_next = W'(lfsr_step(32'(r_lfsr), 32'(TAPS), W));
    // The counter is only ever nonzero during the blanking phase, so a
    // nonzero count doubles as the scroll-step enable.
    assign w_step = step_pix | (r_cnt != 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
            r_cnt  <= 4'd0;
        end else begin
            if (w_step)
                r_lfsr <= w_next;
            if (load_cnt)
                r_cnt <= speed;
            else if (r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    assign lfsr     = r_lfsr;
    assign cnt_zero = (r_cnt == 4'd0);
    assign cnt_one  = (r_cnt == 4'd1);
    assign lit_raw  = &r_lfsr[W-1 -: D];

endmodule

// File: rtl/parallax_starfield.sv
// Multi-layer scrolling starfield. Each layer's LFSR steps once per pixel
// inside the 2^AREA_BITS square window at the origin, plus SPEED[i] extra
// steps during vertical blank, so the layers drift at different rates.
//   clk, reset   : pixel clock, async active-low reset
//   hpos, vpos   : beam position from the sync generator
//   display_on   : visible-area flag
//   scroll_en    : enables the blanking extra-step phase (sampled at trigger)
//   rgb          : winning layer colour, registered
//   star_hit     : any layer lit, registered
//   star_layer   : winning (lowest lit) layer index, registered
//   scroll_busy  : extra-step phase in progress
module parallax_starfield
    import parallax_starfield_pkg::*;
#(
    parameter int                     LAYERS       = 3,
    parameter int                     LFSR_BITS    = 16,
    parameter int                     AREA_BITS    = 8,
    parameter logic [LFSR_BITS-1:0]   TAPS         = 16'h100B,
    parameter logic [LFSR_BITS-1:0]   SEED_BASE    = 16'h0001,
    parameter int                     DENSITY_BITS = 7,
    parameter logic [4*LAYERS-1:0]    SPEED        = {4'd0, 4'd1, 4'd3},
    parameter int                     COLOR_BITS   = 3,
    localparam int                    LW           = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            hpos,
    input  logic [8:0]            vpos,
    input  logic                  display_on,
    input  logic                  scroll_en,
    output logic [COLOR_BITS-1:0] rgb,
    output logic                  star_hit,
    output logic [LW-1:0]         star_layer,
    output logic                  scroll_busy
);

    localparam bit ANY_SPEED = |SPEED;

    state_e                                r_state;
    state_e                                w_state_nxt;
    logic                                  r_armed;
    logic                                  w_win;
    logic                                  w_trig;
    logic                                  w_step_pix;
    logic                                  w_load_cnt;
    logic [LAYERS-1:0][LFSR_BITS-1:0]      w_lfsr;
    logic [LAYERS-1:0]                     w_cnt_zero;
    logic [LAYERS-1:0]                     w_cnt_one;
    logic [LAYERS-1:0]                     w_lit_raw;
    logic [LAYERS-1:0]                     w_lit;
    logic                                  w_any;
    logic [LW-1:0]                         w_idx;
    logic [COLOR_BITS-1:0]                 w_col;
    logic [COLOR_BITS-1:0]                 r_rgb;
    logic                                  r_hit;
    logic [LW-1:0]                         r_layer;
    logic                                  w_unused;

    assign w_win  = ((hpos >> AREA_BITS) == 9'd0) && ((vpos >> AREA_BITS) == 9'd0);
    assign w_trig = (hpos == 9'd0) && (vpos == 9'(1 << AREA_BITS)) && scroll_en;

    assign w_step_pix = (r_state == ST_ACTIVE) && w_win;

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        localparam logic [LFSR_BITS-1:0] SEED =
            LFSR_BITS'(32'(SEED_BASE) + 32'(g) * 32'(SEED_STRIDE));
        starfield_layer #(
            .W    (LFSR_BITS),
            .D    (DENSITY_BITS),
            .TAPS (TAPS),
            .SEED (SEED)
        ) u_layer (
            .clk      (clk),
            .reset    (reset),
            .step_pix (w_step_pix),
            .load_cnt (w_load_cnt),
            .speed    (SPEED[4*g +: 4]),
            .lfsr     (w_lfsr[g]),
            .cnt_zero (w_cnt_zero[g]),
            .cnt_one  (w_cnt_one[g]),
            .lit_raw  (w_lit_raw[g])
        );
    end

    assign w_lit = w_lit_raw & {LAYERS{w_win & display_on}};

    // r_armed blocks a trigger on the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACTIVE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= 1'b1;
        end
    end

    // Leave SCROLL while every counter takes its last step, so the phase
    // lasts exactly max(SPEED) cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_load_cnt  = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (w_trig && r_armed && ANY_SPEED) begin
                    w_state_nxt = ST_SCROLL;
                    w_load_cnt  = 1'b1;
                end
            end
            ST_SCROLL: begin
                if (&(w_cnt_zero | w_cnt_one))
                    w_state_nxt = ST_ACTIVE;
            end
            default: w_state_nxt = ST_ACTIVE;
        endcase
    end

    // Scan from the far layer down so the nearest lit layer wins.
    always_comb begin
        w_any = |w_lit;
        w_idx = '0;
        w_col = '0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (w_lit[i]) begin
                w_idx = LW'(i);
                w_col = w_lfsr[i][COLOR_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb   <= '0;
            r_hit   <= 1'b0;
            r_layer <= '0;
        end else begin
            r_rgb   <= w_col;
            r_hit   <= w_any;
            r_layer <= w_idx;
        end
    end

    assign rgb         = r_rgb;
    assign star_hit    = r_hit;
    assign star_layer  = r_layer;
    assign scroll_busy = (r_state == ST_SCROLL);

    // Only the colour bits of each LFSR reach the outputs.
    assign w_unused = ^w_lfsr;

endmodule

// File: tb/tb_parallax_starfield.sv
module tb_parallax_starfield;

    logic       clk;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on, scroll_en;

    logic [2:0] m_rgb,  d_rgb,  h_rgb;
    logic       m_hit,  d_hit,  h_hit;
    logic [1:0] m_lay,  d_lay;
    logic [0:0] h_lay;
    logic       m_busy, d_busy, h_busy;

    // Main: default density, layer 2 fastest.
    parallax_starfield #(.SPEED(12'h310)) u_main (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .scroll_en(scroll_en),
        .rgb(m_rgb), .star_hit(m_hit), .star_layer(m_lay), .scroll_busy(m_busy));

    // Dense: frequent overlaps exercise the priority encoder.
    parallax_starfield #(.DENSITY_BITS(2)) u_dense (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .scroll_en(scroll_en),
        .rgb(d_rgb), .star_hit(d_hit), .star_layer(d_lay), .scroll_busy(d_busy));

    // Half: one layer, 1-bit density, no scroll speed.
    parallax_starfield #(.LAYERS(1), .DENSITY_BITS(1), .SPEED(4'd0)) u_half (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .scroll_en(scroll_en),
        .rgb(h_rgb), .star_hit(h_hit), .star_layer(h_lay), .scroll_busy(h_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [6:0] e_main;
        logic [6:0] e_dense;
        bit         win_de;
        string      tag;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_lfsr [2][3];
    int          m_cnt  [2][3];
    bit          m_scr  [2];
    bit          m_armed;
    int          spd    [2][3] = '{'{0, 1, 3}, '{3, 1, 0}};
    int          dens   [2]    = '{7, 2};
    int          half_win  = 0;
    int          half_hits = 0;

    function automatic logic [15:0] mstep(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
    endfunction

    function automatic bit mlit(input logic [15:0] s, input int d);
        return (s >> (16 - d)) == (16'hFFFF >> (16 - d));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) begin
                m_lfsr[c][i] = 16'(32'h0001 + i * 32'h1F3D);
                m_cnt[c][i]  = 0;
            end
            m_scr[c] = 0;
        end
        m_armed = 0;
    endtask

    task automatic pixel(input int h, input int v, input bit de, input bit se, input bit rel);
        exp_t e;
        bit   win, trig, done, hit;
        int   lay;
        logic [2:0] col;
        logic [6:0] ev [2];
        logic [6:0] got_m, got_d;
        @(negedge clk);
        if (rel) reset = 1'b1;
        hpos = 9'(h); vpos = 9'(v); display_on = de; scroll_en = se;
        win  = (h < 256) && (v < 256);
        trig = (h == 0) && (v == 256) && se && m_armed;
        for (int c = 0; c < 2; c++) begin
            hit = 0; lay = 0; col = 3'd0;
            for (int i = 2; i >= 0; i--) begin
                if (win && de && mlit(m_lfsr[c][i], dens[c])) begin
                    hit = 1; lay = i; col = m_lfsr[c][i][2:0];
                end
            end
            if (!m_scr[c]) begin
                if (win)
                    for (int i = 0; i < 3; i++) m_lfsr[c][i] = mstep(m_lfsr[c][i]);
                if (trig) begin
                    m_scr[c] = 1;
                    for (int i = 0; i < 3; i++) m_cnt[c][i] = spd[c][i];
                end
            end else begin
                done = 1;
                for (int i = 0; i < 3; i++) begin
                    if (m_cnt[c][i] > 1) done = 0;
                    if (m_cnt[c][i] != 0) begin
                        m_lfsr[c][i] = mstep(m_lfsr[c][i]);
                        m_cnt[c][i]--;
                    end
                end
                if (done) m_scr[c] = 0;
            end
            ev[c] = {m_scr[c], hit, 2'(lay), col};
        end
        m_armed = 1;
        e.e_main = ev[0]; e.e_dense = ev[1]; e.win_de = win && de;
        e.tag = $sformatf("h%0d v%0d", h, v);
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        got_m = {m_busy, m_hit, m_lay, m_rgb};
        got_d = {d_busy, d_hit, d_lay, d_rgb};
        chk({"main ", e.tag}, 32'(got_m), 32'(e.e_main));
        chk({"dense ", e.tag}, 32'(got_d), 32'(e.e_dense));
        chk({"half_busy ", e.tag}, 32'(h_busy), 32'd0);
        chk({"half_layer ", e.tag}, 32'(h_lay), 32'd0);
        if (e.win_de) begin
            half_win++;
            if (h_hit) half_hits++;
        end
    endtask

    // Partial frame: a 48x64 window patch with a display_on gap, pixels
    // outside the window on both axes, then the blanking trigger row.
    task automatic frame(input bit se);
        for (int v = 0; v < 48; v++) begin
            for (int h = 0; h < 64; h++)
                pixel(h, v, !(h >= 40 && h < 44), se, 0);
            pixel(256, v, 1, se, 0);
            pixel(257, v, 1, se, 0);
            pixel(300, v, 1, se, 0);
        end
        for (int h = 0; h < 12; h++)
            pixel(h, 256, 0, (h == 0) ? se : !se, 0);
        for (int h = 0; h < 4; h++)
            pixel(h, 300, 1, 1, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " main"},  32'({m_busy, m_hit, m_lay, m_rgb}), 32'd0);
        chk({tag, " dense"}, 32'({d_busy, d_hit, d_lay, d_rgb}), 32'd0);
        chk({tag, " half"},  32'({h_busy, h_hit, h_lay, h_rgb}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pct;
        reset = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0; scroll_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");

        // Release coincident with a trigger pixel: must be ignored.
        model_reset();
        pixel(0, 256, 0, 1, 1);
        pixel(1, 256, 0, 0, 0);

        frame(0);
        repeat (4) frame(1);
        frame(0);

        // Async reset during the second scroll cycle.
        pixel(0, 256, 0, 1, 0);
        pixel(1, 256, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk_zero("reset_mid_scroll");
        model_reset();
        pixel(5, 256, 0, 1, 1);
        frame(1);
        frame(1);

        pct = (half_win > 0) ? (half_hits * 100) / half_win : 0;
        chk($sformatf("half_density %0d/%0d", half_hits, half_win),
            32'(pct >= 45 && pct <= 55), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
